out_port_uart_tx: RTL and testbench

//  Sink for the CPU output port (out_o / out_ld_o). Captures each word the CPU

---
 rtl/out_port_uart_tx.sv | 215 +++++++++++++++++++++
 tb/tb_out_port_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx
// Sink for the CPU output port. Each word strobed in by the CPU is queued in a
// small FIFO and sent MSB byte first as UART frames on tx_o. Also latches the
// CPU halt and reports when every captured word has been sent.
// Optional feature: define OUT_PORT_PARITY_EN to add an even parity bit to
// every byte (8E1 frames). Without it, frames are 8N1. The port list is the
// same in both builds.
module out_port_uart_tx #(
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int CLKS_PER_BIT    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  out_ld_i,
    input  logic [DATA_WIDTH-1:0] out_i,
    input  logic                  halt_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  drained_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W = FIFO_DEPTH_LOG2;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef OUT_PORT_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0]      byte_idx;
    logic [2:0]            bit_cnt;
    logic [TMR_W-1:0]      bit_timer;
    logic                  bit_done;
    logic [7:0]            cur_byte;
    logic                  line_bit;
    logic                  halt_latch;

    // A pop happens whenever the serialiser is idle and a word is waiting.
    // A push while full is only accepted if the same cycle frees a slot.
    assign fifo_empty = (count == '0);
    assign pop        = (state == IDLE) && !fifo_empty;
    assign push       = out_ld_i && ((count != DEPTH_CNT) || pop);
    assign cur_byte   = shift_reg[DATA_WIDTH-1 -: 8];
    assign bit_done   = (bit_timer == TMR_LAST);

    // Next FIFO occupancy from this cycle's push/pop pair
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage: the accepted word lands at the write pointer
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= out_i;
        end
    end

    // FIFO pointers, occupancy, full flag and sticky overflow flag
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count  <= count_next;
            full_o <= (count_next == DEPTH_CNT);
            if (out_ld_i && !push) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Sticky record that the CPU has halted at least once since reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            halt_latch <= 1'b0;
        end else if (halt_i) begin
            halt_latch <= 1'b1;
        end
    end

    // Serial line level implied by the current state and bit position
    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = cur_byte[bit_cnt];
`ifdef OUT_PORT_PARITY_EN
            PARITY:  line_bit = ^cur_byte;
`endif
            default: line_bit = 1'b1;
        endcase
    end

    // Frame sequencer with registered line, busy and drained outputs
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_idx  <= '0;
            bit_cnt   <= '0;
            bit_timer <= '0;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
            drained_o <= 1'b0;
        end else begin
            tx_o      <= line_bit;
            busy_o    <= (state != IDLE);
            drained_o <= halt_latch && fifo_empty && (state == IDLE);
            case (state)
                IDLE: begin
                    bit_timer <= '0;
                    bit_cnt   <= '0;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_mem[rd_ptr];
                        byte_idx  <= IDX_FIRST;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        bit_cnt   <= '0;
                        state     <= DATA;
                    end else begin
                        bit_timer <= bit_timer + TMR_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef OUT_PORT_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        bit_timer <= bit_timer + TMR_W'(1);
                    end
                end
`ifdef OUT_PORT_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        state     <= STOP;
                    end else begin
                        bit_timer <= bit_timer + TMR_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        if (byte_idx != '0) begin
                            byte_idx  <= byte_idx - IDX_W'(1);
                            shift_reg <= shift_reg << 8;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_timer <= bit_timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb_out_port_uart_tx
// Drives out_port_uart_tx with directed and random CPU output-port traffic.
// A queue-level reference model predicts FIFO acceptance, flags and busy time;
// a UART receiver decodes tx_o and compares each byte with the model.
`timescale 1ns/1ps
module tb_out_port_uart_tx;

    localparam int DW    = 16;
    localparam int FLOG  = 2;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;
`ifdef OUT_PORT_PARITY_EN
    localparam int BITS_PER_FRAME = 11;
`else
    localparam int BITS_PER_FRAME = 10;
`endif
    localparam int WORD_CYCLES = (DW / 8) * BITS_PER_FRAME * CPB;
    localparam int PAR_SAMPLE  = CPB * 9 + HALF;
    localparam int STOP_SAMPLE = CPB * (BITS_PER_FRAME - 1) + HALF;

    logic          Clock_TB;
    logic          reset_n;
    logic          out_ld;
    logic [DW-1:0] out_data;
    logic          halt_in;
    logic          tx;
    logic          busy;
    logic          full;
    logic          overflow;
    logic          drained;

    int tests_run    = 0;
    int tests_failed = 0;

    out_port_uart_tx #(
        .DATA_WIDTH      (DW),
        .FIFO_DEPTH_LOG2 (FLOG),
        .CLKS_PER_BIT    (CPB)
    ) dut (
        .clk_i      (Clock_TB),
        .reset_ni   (reset_n),
        .out_ld_i   (out_ld),
        .out_i      (out_data),
        .halt_i     (halt_in),
        .tx_o       (tx),
        .busy_o     (busy),
        .full_o     (full),
        .overflow_o (overflow),
        .drained_o  (drained)
    );

    initial Clock_TB = 1'b0;
    always #5 Clock_TB = ~Clock_TB;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs at the falling edge
    task automatic applyStimulus(input logic ld, input logic [DW-1:0] data, input logic halt);
        @(negedge Clock_TB);
        out_ld   = ld;
        out_data = data;
        halt_in  = halt;
    endtask

    // Reference model: words waiting, cycles the transmitter stays busy per word
    logic [DW-1:0] word_q[$];
    logic [7:0]    exp_bytes[$];
    int            busy_left   = 0;
    logic          halt_seen   = 1'b0;
    logic          exp_busy    = 1'b0;
    logic          exp_full    = 1'b0;
    logic          exp_ovf     = 1'b0;
    logic          exp_drained = 1'b0;
    int            m_pre_busy;
    int            m_pre_size;
    logic          m_pre_halt;
    logic          m_pop;
    logic          m_accept;
    logic [DW-1:0] m_word;

    always @(posedge Clock_TB or negedge reset_n) begin
        if (!reset_n) begin
            word_q.delete();
            exp_bytes.delete();
            busy_left   = 0;
            halt_seen   = 1'b0;
            exp_busy    = 1'b0;
            exp_full    = 1'b0;
            exp_ovf     = 1'b0;
            exp_drained = 1'b0;
        end else begin
            m_pre_busy = busy_left;
            m_pre_size = word_q.size();
            m_pre_halt = halt_seen;
            m_pop      = (m_pre_busy == 0) && (m_pre_size > 0);
            m_accept   = out_ld && ((m_pre_size < DEPTH) || m_pop);
            if (m_pop) begin
                m_word = word_q.pop_front();
                exp_bytes.push_back(m_word[15:8]);
                exp_bytes.push_back(m_word[7:0]);
                busy_left = WORD_CYCLES;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            if (m_accept) word_q.push_back(out_data);
            if (out_ld && !m_accept) exp_ovf = 1'b1;
            if (halt_in) halt_seen = 1'b1;
            exp_busy    = (m_pre_busy > 0);
            exp_full    = (word_q.size() == DEPTH);
            exp_drained = m_pre_halt && (m_pre_size == 0) && (m_pre_busy == 0);
        end
    end

    // Per-cycle flag checks plus a UART receiver sampling mid-bit on tx
    int         rx_phase = -1;
    logic [7:0] rx_byte  = 8'h00;
    logic [7:0] rx_log[$];
    logic       rx_par_log[$];

    always @(negedge Clock_TB) begin
        checkOutput("busy_o", busy, exp_busy);
        checkOutput("full_o", full, exp_full);
        checkOutput("overflow_o", overflow, exp_ovf);
        checkOutput("drained_o", drained, exp_drained);
        if (!reset_n) begin
            rx_phase = -1;
        end else if (rx_phase < 0) begin
            if (tx == 1'b0) rx_phase = 0;
        end else begin
            rx_phase++;
            if (rx_phase == HALF) begin
                checkOutput("start_bit", tx, 1'b0);
            end else if (rx_phase >= CPB + HALF && rx_phase <= CPB * 8 + HALF &&
                         ((rx_phase - HALF) % CPB) == 0) begin
                rx_byte[(rx_phase - HALF) / CPB - 1] = tx;
`ifdef OUT_PORT_PARITY_EN
            end else if (rx_phase == PAR_SAMPLE) begin
                checkOutput("parity_bit", tx, ^rx_byte);
                rx_par_log.push_back(tx);
`endif
            end else if (rx_phase == STOP_SAMPLE) begin
                checkOutput("stop_bit", tx, 1'b1);
                rx_log.push_back(rx_byte);
                if (exp_bytes.size() > 0) begin
                    checkOutput("rx_byte", rx_byte, exp_bytes.pop_front());
                end else begin
                    checkOutput("rx_spurious", exp_bytes.size(), 1);
                end
                rx_phase = -1;
            end
        end
    end

    // Wait until the model and receiver agree everything queued has been sent
    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while (!(word_q.size() == 0 && busy_left == 0 && exp_bytes.size() == 0 && rx_phase < 0)
               && n < max_cycles) begin
            @(negedge Clock_TB);
            n++;
        end
        checkOutput("drain_timeout", (n < max_cycles), 1'b1);
        repeat (5) @(negedge Clock_TB);
    endtask

    // Count busy samples and locate the first low tx sample after a strobe
    task automatic measureFrame(output int busy_cycles, output int first_low);
        busy_cycles = 0;
        first_low   = -1;
        for (int i = 1; i <= 150; i++) begin
            @(negedge Clock_TB);
            if (busy) busy_cycles++;
            if (first_low < 0 && tx == 1'b0) first_low = i;
        end
    endtask

    // Watchdog so a stuck design still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time %0t reached, required finish before 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios interleaved with a random traffic phase
    initial begin
        int            busy_cnt;
        int            first_low;
        logic [DW-1:0] d [6];

        reset_n  = 1'b0;
        out_ld   = 1'b0;
        out_data = '0;
        halt_in  = 1'b0;

        repeat (2) @(negedge Clock_TB);
        checkOutput("rst_tx", tx, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_full", full, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_drained", drained, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge Clock_TB);

        $display("[TB] single word 0xA55A");
        rx_log.delete();
        applyStimulus(1'b1, 16'hA55A, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t2_tx_before_fall", tx, 1'b1);
        measureFrame(busy_cnt, first_low);
        checkOutput("t2_tx_fall_edge", first_low, 2);
        checkOutput("t2_busy_cycles", busy_cnt, WORD_CYCLES);
        waitDrain(500);
        checkOutput("t2_rx_count", rx_log.size(), 2);
        checkOutput("t2_byte0", rx_log[0], 8'hA5);
        checkOutput("t2_byte1", rx_log[1], 8'h5A);

        $display("[TB] six back-to-back strobes");
        rx_log.delete();
        for (int i = 0; i < 6; i++) d[i] = DW'($urandom);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, d[i], 1'b0);
        checkOutput("t3_full", full, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t3_overflow", overflow, 1'b1);
        waitDrain(1000);
        checkOutput("t3_rx_count", rx_log.size(), 10);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_word_hi", rx_log[2 * i], d[i][15:8]);
            checkOutput("t3_word_lo", rx_log[2 * i + 1], d[i][7:0]);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), DW'($urandom), 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0);
        waitDrain(1500);

        $display("[TB] halt with three words queued");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t4_drained_early", drained, 1'b0);
        waitDrain(1000);
        checkOutput("t4_drained", drained, 1'b1);
        repeat (10) @(negedge Clock_TB);
        checkOutput("t4_drained_sticky", drained, 1'b1);
        applyStimulus(1'b1, DW'($urandom), 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        @(negedge Clock_TB);
        checkOutput("t4_drained_drop", drained, 1'b0);
        waitDrain(500);
        checkOutput("t4_drained_again", drained, 1'b1);

        $display("[TB] reset during second byte");
        rx_log.delete();
        applyStimulus(1'b1, DW'($urandom), 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        repeat (60) @(negedge Clock_TB);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t5_tx_now", tx, 1'b1);
        checkOutput("t5_busy_now", busy, 1'b0);
        checkOutput("t5_full_now", full, 1'b0);
        checkOutput("t5_overflow_now", overflow, 1'b0);
        checkOutput("t5_drained_now", drained, 1'b0);
        repeat (2) @(negedge Clock_TB);
        reset_n = 1'b1;
        checkOutput("t5_rx_partial", rx_log.size(), 1);
        repeat (2) @(negedge Clock_TB);
        rx_log.delete();
        applyStimulus(1'b1, 16'h0102, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        waitDrain(500);
        checkOutput("t5_rx_count", rx_log.size(), 2);
        checkOutput("t5_byte0", rx_log[0], 8'h01);
        checkOutput("t5_byte1", rx_log[1], 8'h02);

        $display("[TB] word 0x0703 frame timing");
        rx_log.delete();
        rx_par_log.delete();
        applyStimulus(1'b1, 16'h0703, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        measureFrame(busy_cnt, first_low);
        checkOutput("t6_busy_cycles", busy_cnt, WORD_CYCLES);
        waitDrain(500);
        checkOutput("t6_byte0", rx_log[0], 8'h07);
        checkOutput("t6_byte1", rx_log[1], 8'h03);
`ifdef OUT_PORT_PARITY_EN
        checkOutput("t6_parity_count", rx_par_log.size(), 2);
        checkOutput("t6_parity0", rx_par_log[0], 1'b1);
        checkOutput("t6_parity1", rx_par_log[1], 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
